// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing constants shared by the raster pipeline
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int CLK_DIV   = 4;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster timing bundle from the sync generator to the pixel generators
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_tick;

    modport master (
        output p_tick,
        output pixel_x,
        output pixel_y,
        output hsync,
        output vsync,
        output video_on,
        output frame_tick
    );

    modport slave (
        input p_tick,
        input pixel_x,
        input pixel_y,
        input hsync,
        input vsync,
        input video_on,
        input frame_tick
    );

endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled modulo-MOD counter with combinational terminal-count flag
module mod_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = (cnt_q == W'(MOD - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-enable divider, h/v raster counters and registered sync decode
module vga_sync_gen
    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::COORD_W;
#(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga_o
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam coord_t H_VIS_END    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS_END    = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SYNC_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t V_SYNC_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SYNC_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             div_last;

    logic p_tick_q;
    logic frame_tick_q;
    logic hsync_q;
    logic vsync_q;
    logic video_on_q;

    coord_t x_cnt;
    coord_t y_cnt;
    coord_t x_d;
    coord_t y_d;
    logic   h_wrap;
    logic   v_wrap;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d    = div_last ? '0 : div_q + DIV_W'(1);

    // Counters advance on the edge that closes the p_tick cycle
    mod_counter #(
        .MOD (H_TOTAL),
        .W   (COORD_W)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (p_tick_q),
        .cnt   (x_cnt),
        .wrap  (h_wrap)
    );

    mod_counter #(
        .MOD (V_TOTAL),
        .W   (COORD_W)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (p_tick_q & h_wrap),
        .cnt   (y_cnt),
        .wrap  (v_wrap)
    );

    // Next coordinates, so the registered decode lines up with the registered counters
    always_comb begin
        x_d = x_cnt;
        y_d = y_cnt;
        if (p_tick_q) begin
            x_d = h_wrap ? '0 : x_cnt + coord_t'(1);
            if (h_wrap) begin
                y_d = v_wrap ? '0 : y_cnt + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            p_tick_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
        end else begin
            div_q        <= div_d;
            p_tick_q     <= div_last;
            // Counters hold across this edge (p_tick_q is low), so x/y are already final
            frame_tick_q <= div_last && h_wrap && v_wrap;
            hsync_q      <= !((x_d >= H_SYNC_START) && (x_d < H_SYNC_END));
            vsync_q      <= !((y_d >= V_SYNC_START) && (y_d < V_SYNC_END));
            video_on_q   <= (x_d < H_VIS_END) && (y_d < V_VIS_END);
        end
    end

    assign vga_o.p_tick     = p_tick_q;
    assign vga_o.pixel_x    = x_cnt;
    assign vga_o.pixel_y    = y_cnt;
    assign vga_o.hsync      = hsync_q;
    assign vga_o.vsync      = vsync_q;
    assign vga_o.video_on   = video_on_q;
    assign vga_o.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - raster generator bench on a shrunken timing so whole frames stay short
module tb_vga_sync_gen;

    localparam int CLK_DIV = 4;
    localparam int H_DISP  = 40;
    localparam int H_FP    = 4;
    localparam int H_SW    = 8;
    localparam int H_BP    = 4;
    localparam int V_DISP  = 12;
    localparam int V_FP    = 2;
    localparam int V_SW    = 2;
    localparam int V_BP    = 3;
    localparam int H_TOT   = H_DISP + H_FP + H_SW + H_BP;
    localparam int V_TOT   = V_DISP + V_FP + V_SW + V_BP;
    localparam int FRAME   = CLK_DIV * H_TOT * V_TOT;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       ft;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_edges;
    int   checks = 0;
    int   errors = 0;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .CLK_DIV   (CLK_DIV),
        .H_DISPLAY (H_DISP),
        .H_FRONT   (H_FP),
        .H_SYNC    (H_SW),
        .H_BACK    (H_BP),
        .V_DISPLAY (V_DISP),
        .V_FRONT   (V_FP),
        .V_SYNC    (V_SW),
        .V_BACK    (V_BP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga_o (vif)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset released; the whole raster is a function of this count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    function automatic obs_t model(int n);
        obs_t e;
        int k, x, y;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (n == 0) return e;
        k        = (n - 1) / CLK_DIV;
        x        = k % H_TOT;
        y        = (k / H_TOT) % V_TOT;
        e.p_tick = (n % CLK_DIV) == 0;
        e.x      = 10'(x);
        e.y      = 10'(y);
        e.hs     = !(x >= H_DISP + H_FP && x < H_DISP + H_FP + H_SW);
        e.vs     = !(y >= V_DISP + V_FP && y < V_DISP + V_FP + V_SW);
        e.vo     = (x < H_DISP) && (y < V_DISP);
        e.ft     = e.p_tick && (x == H_TOT - 1) && (y == V_TOT - 1);
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.p_tick = vif.p_tick;
        o.x      = vif.pixel_x;
        o.y      = vif.pixel_y;
        o.hs     = vif.hsync;
        o.vs     = vif.vsync;
        o.vo     = vif.video_on;
        o.ft     = vif.frame_tick;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst_n = 1'b0;
        repeat (10) begin
            tick();
            o = sample();
            e = model(0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset got %h exp %h", o, e);
            end
        end
    endtask

    task automatic test_divider();
        obs_t o, e;
        int first_p = -1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < CLK_DIV * 6; i++) begin
            tick();
            o = sample();
            e = model(n_edges);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL divider n=%0d got %h exp %h", n_edges, o, e);
            end
            if (o.p_tick && first_p < 0) first_p = n_edges;
            if (n_edges == CLK_DIV + 1) begin
                checks++;
                if (o.x !== 10'd1) begin
                    errors++;
                    $display("FAIL first_pixel got x=%0d exp 1", o.x);
                end
            end
        end
        checks++;
        if (first_p != CLK_DIV) begin
            errors++;
            $display("FAIL first_ptick got clk %0d exp %0d", first_p, CLK_DIV);
        end
    endtask

    task automatic test_line();
        obs_t o, e;
        int hs_low = 0, vo_on = 0, hs_first_x = -1;
        logic hs_prev = 1'b1;
        for (int i = 0; i < CLK_DIV * H_TOT; i++) begin
            tick();
            o = sample();
            e = model(n_edges);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL line n=%0d got %h exp %h", n_edges, o, e);
            end
            if (!o.hs) hs_low++;
            if (o.vo) vo_on++;
            if (hs_prev && !o.hs && hs_first_x < 0) hs_first_x = int'(o.x);
            hs_prev = o.hs;
        end
        checks++;
        if (hs_low != CLK_DIV * H_SW) begin
            errors++;
            $display("FAIL hsync_width got %0d clks exp %0d", hs_low, CLK_DIV * H_SW);
        end
        checks++;
        if (hs_first_x != H_DISP + H_FP) begin
            errors++;
            $display("FAIL hsync_start got x=%0d exp %0d", hs_first_x, H_DISP + H_FP);
        end
        checks++;
        if (vo_on != CLK_DIV * H_DISP) begin
            errors++;
            $display("FAIL video_on_width got %0d clks exp %0d", vo_on, CLK_DIV * H_DISP);
        end
    endtask

    task automatic test_frame();
        obs_t o, e;
        int vs_low = 0, ft_cnt = 0, last_ft = -1, bad_period = 0;
        for (int i = 0; i < 2 * FRAME + 64; i++) begin
            tick();
            o = sample();
            e = model(n_edges);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL align n=%0d got %h exp %h", n_edges, o, e);
            end
            if (i < FRAME && !o.vs) vs_low++;
            if (o.ft) begin
                if (last_ft >= 0 && n_edges - last_ft != FRAME) bad_period++;
                last_ft = n_edges;
                ft_cnt++;
            end
        end
        checks++;
        if (vs_low != CLK_DIV * H_TOT * V_SW) begin
            errors++;
            $display("FAIL vsync_width got %0d clks exp %0d", vs_low, CLK_DIV * H_TOT * V_SW);
        end
        checks++;
        if (ft_cnt < 2 || bad_period != 0) begin
            errors++;
            $display("FAIL frame_period got %0d ticks %0d bad periods exp >=2 and 0", ft_cnt, bad_period);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int tx, ty, hold, first_ft = -1;
        bit found = 1'b0;
        tx = $urandom_range(H_DISP + H_FP + H_SW - 1, H_DISP + H_FP);
        ty = $urandom_range(V_TOT - 1, 0);
        hold = $urandom_range(8, 2);
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            tick();
            o = sample();
            e = model(n_edges);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pre_reset n=%0d got %h exp %h", n_edges, o, e);
            end
            if (int'(o.x) == tx && int'(o.y) == ty && !o.hs) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_point got none exp (%0d,%0d) with hsync low", tx, ty);
        end
        #3;
        rst_n = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== model(0)) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", o, model(0));
        end
        repeat (hold) begin
            tick();
            o = sample();
            checks++;
            if (o !== model(0)) begin
                errors++;
                $display("FAIL reset_hold got %h exp %h", o, model(0));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 32; c++) begin
            tick();
            o = sample();
            e = model(n_edges);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset n=%0d got %h exp %h", n_edges, o, e);
            end
            if (o.ft && first_ft < 0) first_ft = n_edges;
        end
        checks++;
        if (first_ft != FRAME) begin
            errors++;
            $display("FAIL first_frame_tick got clk %0d exp %0d", first_ft, FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line();
        test_frame();
        test_reset_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
